// File: rtl/zeus_axis_pkg.sv
// Shared AXI-Stream types and helpers for the packet arbiter datapath.
package zeus_axis_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // A single-port build still needs a one-bit id field.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXIS output register: a new load may overwrite a beat that is
// handshaking in the same cycle, so a ready downstream sees no bubbles.
module axis_out_reg #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] load_data,
    output logic                 out_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PAYLOAD_W-1:0] m_data
);

    logic                 vld_p1;
    logic [PAYLOAD_W-1:0] data_p1;

    assign out_ready = !vld_p1 || m_ready;
    assign m_valid   = vld_p1;
    assign m_data    = data_p1;

    // Output stage: payload stays put after a handshake, only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= load_data;
        end else if (vld_p1 && m_ready) begin
            vld_p1  <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin AXIS arbiter: a grant is held from the first
// beat to tlast, and the winning port index is forwarded on m_axis_tid.
module axis_pkt_arbiter
    import zeus_axis_pkg::*;
#(
    parameter  int NUM_PORTS   = 4,
    parameter  int TDATA_WIDTH = 512,
    localparam int IDW         = clog2_min1(NUM_PORTS)
) (
    input  logic                               s_aclk,
    input  logic                               s_aresetn,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]               s_axis_tlast,
    input  logic [NUM_PORTS-1:0]               s_axis_tvalid,
    output logic [NUM_PORTS-1:0]               s_axis_tready,
    output logic [TDATA_WIDTH-1:0]             m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic                               m_axis_tlast,
    output logic [IDW-1:0]                     m_axis_tid,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               busy
);

    localparam int KEEP_W    = TDATA_WIDTH / 8;
    localparam int PAYLOAD_W = IDW + 1 + KEEP_W + TDATA_WIDTH;

    arb_state_e             state;
    logic [IDW-1:0]         grant;
    logic [IDW-1:0]         last_grant;
    logic [IDW-1:0]         pick;
    logic [TDATA_WIDTH-1:0] sel_data;
    logic [KEEP_W-1:0]      sel_keep;
    logic                   sel_last;
    logic                   sel_valid;
    logic                   out_ready;
    logic                   accept;
    logic [PAYLOAD_W-1:0]   load_data;
    logic [PAYLOAD_W-1:0]   out_data;

    // Scan last+1, last+2, ... so the port that just finished ranks lowest.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDW-1:0]       last);
        logic [IDW:0]   idx;
        logic [IDW-1:0] sel;
        logic           found;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = {1'b0, last} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NUM_PORTS))
                idx = idx - (IDW+1)'(NUM_PORTS);
            if (!found && req[idx[IDW-1:0]]) begin
                sel   = idx[IDW-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(s_axis_tvalid, last_grant);

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant == IDW'(p)) begin
                sel_data  = s_axis_tdata[p*TDATA_WIDTH +: TDATA_WIDTH];
                sel_keep  = s_axis_tkeep[p*KEEP_W +: KEEP_W];
                sel_last  = s_axis_tlast[p];
                sel_valid = s_axis_tvalid[p];
            end
        end
    end

    // Ready is combinational from m_axis_tready so a streaming packet never stalls.
    always_comb begin
        s_axis_tready = '0;
        if (state == LOCKED)
            s_axis_tready[grant] = out_ready;
    end

    assign accept    = (state == LOCKED) && sel_valid && out_ready;
    assign load_data = {grant, sel_last, sel_keep, sel_data};

    axis_out_reg #(
        .PAYLOAD_W(PAYLOAD_W)
    ) u_out_reg (
        .clk      (s_aclk),
        .rst_n    (s_aresetn),
        .load     (accept),
        .load_data(load_data),
        .out_ready(out_ready),
        .m_valid  (m_axis_tvalid),
        .m_ready  (m_axis_tready),
        .m_data   (out_data)
    );

    assign {m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_data;

    // Arbitration stage: grant is locked until the granted port's tlast is accepted.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDW'(NUM_PORTS - 1);
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant <= pick;
                        state <= LOCKED;
                        busy  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (accept && sel_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomised bench for axis_pkt_arbiter with a transaction-level arbitration
// model, a per-port data scoreboard and directed scenario checks.
module tb_axis_pkt_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int IDW = 2;

    logic                s_aclk;
    logic                s_aresetn;
    logic [NP*DW-1:0]    s_axis_tdata;
    logic [NP*KW-1:0]    s_axis_tkeep;
    logic [NP-1:0]       s_axis_tlast;
    logic [NP-1:0]       s_axis_tvalid;
    logic [NP-1:0]       s_axis_tready;
    logic [DW-1:0]       m_axis_tdata;
    logic [KW-1:0]       m_axis_tkeep;
    logic                m_axis_tlast;
    logic [IDW-1:0]      m_axis_tid;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                busy;

    axis_pkt_arbiter #(
        .NUM_PORTS  (NP),
        .TDATA_WIDTH(DW)
    ) dut (
        .s_aclk       (s_aclk),
        .s_aresetn    (s_aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tid   (m_axis_tid),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy         (busy)
    );

    initial s_aclk = 1'b0;
    always #5 s_aclk = ~s_aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            gap;
        int            port;
    } beat_t;

    beat_t srcq[NP][$];
    beat_t expq[NP][$];
    beat_t gen_log[$];
    beat_t out_log[$];
    int    start_log[$];
    bit    vhist[$];
    bit    presenting[NP];
    int    gapleft[NP];
    int    acc_cnt[NP];

    // Reference arbitration state: owner = -1 means nobody holds the output.
    int    m_owner, m_last, m_tid;
    bit    m_vld;
    bit    prev_last;
    int    prev_tid;
    int    mready_mode;
    bit    tog;
    logic [NP-1:0] rdy_snap;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int p, input int n, input int gap0, input int gapmid, input int gap_at);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = DW'($urandom);
            b.keep = KW'($urandom_range(1, (1 << KW) - 1));
            b.last = (i == n - 1);
            b.gap  = (i == 0) ? gap0 : ((i == gap_at) ? gapmid : 0);
            b.port = p;
            srcq[p].push_back(b);
            gen_log.push_back(b);
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            if (!presenting[p] && srcq[p].size() > 0) begin
                if (gapleft[p] < 0) gapleft[p] = srcq[p][0].gap;
                if (gapleft[p] == 0) begin
                    presenting[p] = 1'b1;
                    gapleft[p]    = -1;
                end else begin
                    gapleft[p]--;
                end
            end
            s_axis_tvalid[p] = presenting[p];
            if (presenting[p]) begin
                s_axis_tdata[p*DW +: DW] = srcq[p][0].data;
                s_axis_tkeep[p*KW +: KW] = srcq[p][0].keep;
                s_axis_tlast[p]          = srcq[p][0].last;
            end else begin
                s_axis_tdata[p*DW +: DW] = DW'($urandom);
                s_axis_tkeep[p*KW +: KW] = '0;
                s_axis_tlast[p]          = 1'($urandom_range(0, 1));
            end
        end
        case (mready_mode)
            0:       m_axis_tready = 1'b1;
            1: begin tog = ~tog; m_axis_tready = tog; end
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic score_out();
        int    t;
        beat_t b;
        t = int'(m_axis_tid);
        if (!prev_last) check("no_interleave", 64'(t), 64'(prev_tid));
        if (expq[t].size() == 0) begin
            check("sb_beat_expected", 64'(0), 64'(1));
        end else begin
            b = expq[t].pop_front();
            check("sb_tdata", 64'(m_axis_tdata), 64'(b.data));
            check("sb_tkeep", 64'(m_axis_tkeep), 64'(b.keep));
            check("sb_tlast", 64'(m_axis_tlast), 64'(b.last));
        end
        if (prev_last) start_log.push_back(t);
        b.data = m_axis_tdata;
        b.keep = m_axis_tkeep;
        b.last = m_axis_tlast;
        b.gap  = 0;
        b.port = t;
        out_log.push_back(b);
        prev_last = m_axis_tlast;
        prev_tid  = t;
    endtask

    task automatic step();
        logic [NP-1:0] exp_rdy, acc;
        bit hs, acc_m, was_idle;
        int pick;
        @(negedge s_aclk);
        drive_inputs();
        #1;
        exp_rdy = '0;
        if (m_owner >= 0 && (!m_vld || m_axis_tready)) exp_rdy[m_owner] = 1'b1;
        check("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        rdy_snap = s_axis_tready;
        acc = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) score_out();
        @(posedge s_aclk);
        hs       = m_vld && m_axis_tready;
        was_idle = (m_owner < 0);
        acc_m    = !was_idle && exp_rdy[m_owner] && s_axis_tvalid[m_owner];
        if (acc_m) begin
            m_vld = 1'b1;
            m_tid = m_owner;
            if (s_axis_tlast[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (hs) begin
            m_vld = 1'b0;
        end
        if (was_idle) begin
            pick = -1;
            for (int k = 1; k <= NP; k++)
                if (pick < 0 && s_axis_tvalid[(m_last + k) % NP]) pick = (m_last + k) % NP;
            m_owner = pick;
        end
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                expq[p].push_back(srcq[p].pop_front());
                presenting[p] = 1'b0;
                acc_cnt[p]++;
            end
        end
        #1;
        check("m_tvalid", 64'(m_axis_tvalid), 64'(m_vld));
        check("busy", 64'(busy), 64'(m_owner >= 0));
        if (m_vld) check("m_tid", 64'(m_axis_tid), 64'(m_tid));
        vhist.push_back(m_axis_tvalid);
    endtask

    function automatic bit pending();
        for (int p = 0; p < NP; p++)
            if (srcq[p].size() > 0 || expq[p].size() > 0) return 1'b1;
        return m_vld || (m_owner >= 0);
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int c = 0;
        while (pending() && c < budget) begin
            step();
            c++;
        end
        check({name, "_drained_in_budget"}, 64'(c < budget), 64'(1));
    endtask

    task automatic reset_dut();
        @(negedge s_aclk);
        #2;
        s_aresetn = 1'b0;
        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_s_tready", 64'(s_axis_tready), 64'(0));
        check("rst_busy",     64'(busy),          64'(0));
        check("rst_m_tlast",  64'(m_axis_tlast),  64'(0));
        check("rst_m_tid",    64'(m_axis_tid),    64'(0));
        check("rst_m_tdata",  64'(m_axis_tdata),  64'(0));
        check("rst_m_tkeep",  64'(m_axis_tkeep),  64'(0));
        m_owner = -1; m_last = NP - 1; m_vld = 1'b0; m_tid = 0;
        prev_last = 1'b1; prev_tid = 0; tog = 1'b0;
        for (int p = 0; p < NP; p++) begin
            srcq[p].delete(); expq[p].delete();
            presenting[p] = 1'b0; gapleft[p] = -1; acc_cnt[p] = 0;
        end
        gen_log.delete(); out_log.delete(); start_log.delete(); vhist.delete();
        s_axis_tvalid = '0;
        repeat (2) @(negedge s_aclk);
        s_aresetn = 1'b1;
    endtask

    int t2_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        s_aresetn     = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        mready_mode   = 0;

        // Port 2, 3-beat packet, downstream always ready.
        reset_dut();
        add_pkt(2, 3, 0, 0, 3);
        step();
        check("t1_busy_after_grant", 64'(busy), 64'(1));
        step();
        check("t1_ready_port2", 64'(rdy_snap), 64'(4'b0100));
        run_until_idle("t1", 100);
        check("t1_nbeats", 64'(out_log.size()), 64'(3));
        for (int i = 0; i < 3 && i < out_log.size(); i++) begin
            check("t1_tid", 64'(out_log[i].port), 64'(2));
            check("t1_tlast", 64'(out_log[i].last), 64'(i == 2));
        end

        // All ports requesting: round-robin order 0,1,2,3,0.
        reset_dut();
        for (int p = 0; p < NP; p++) add_pkt(p, 2, 0, 0, 2);
        add_pkt(0, 2, 0, 0, 2);
        run_until_idle("t2", 200);
        check("t2_npkts", 64'(start_log.size()), 64'(5));
        for (int i = 0; i < 5 && i < start_log.size(); i++)
            check("t2_order", 64'(start_log[i]), 64'(t2_exp[i]));

        // Port 1 stalls mid-packet while port 3 waits.
        reset_dut();
        add_pkt(1, 3, 0, 5, 1);
        add_pkt(3, 1, 2, 0, 1);
        run_until_idle("t3", 200);
        check("t3_npkts", 64'(start_log.size()), 64'(2));
        if (start_log.size() == 2) begin
            check("t3_first", 64'(start_log[0]), 64'(1));
            check("t3_second", 64'(start_log[1]), 64'(3));
        end

        // Toggling downstream ready over a 4-beat packet.
        reset_dut();
        mready_mode = 1;
        add_pkt(2, 4, 0, 0, 4);
        run_until_idle("t4", 200);
        check("t4_nbeats", 64'(out_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            check("t4_data", 64'(out_log[i].data), 64'(gen_log[i].data));

        // Back-to-back single-beat packets from port 0.
        reset_dut();
        mready_mode = 0;
        for (int i = 0; i < 4; i++) add_pkt(0, 1, 0, 0, 1);
        run_until_idle("t5", 100);
        begin
            int i0 = -1;
            for (int i = 0; i < vhist.size(); i++) if (i0 < 0 && vhist[i]) i0 = i;
            check("t5_hist_len", 64'(i0 >= 0 && i0 + 7 <= vhist.size()), 64'(1));
            if (i0 >= 0)
                for (int k = 0; k < 7 && i0 + k < vhist.size(); k++)
                    check("t5_valid_pattern", 64'(vhist[i0 + k]), 64'(k % 2 == 0));
        end

        // Reset after beat 2 of a 5-beat packet, then port 0 wins again.
        reset_dut();
        add_pkt(0, 5, 0, 0, 5);
        begin
            int c = 0;
            while (acc_cnt[0] < 2 && c < 50) begin step(); c++; end
            check("t6_two_beats_in", 64'(acc_cnt[0]), 64'(2));
        end
        check("t6_valid_before_reset", 64'(m_axis_tvalid), 64'(1));
        reset_dut();
        add_pkt(2, 1, 0, 0, 1);
        add_pkt(0, 1, 0, 0, 1);
        run_until_idle("t6", 100);
        check("t6_npkts", 64'(start_log.size()), 64'(2));
        if (start_log.size() == 2) begin
            check("t6_first", 64'(start_log[0]), 64'(0));
            check("t6_second", 64'(start_log[1]), 64'(2));
        end

        // Random traffic, gaps and backpressure.
        reset_dut();
        mready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            int n;
            n = int'($urandom_range(1, 5));
            add_pkt(int'($urandom_range(0, NP - 1)), n, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, n)));
        end
        run_until_idle("rand", 8000);
        check("rand_npkts", 64'(start_log.size()), 64'(60));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
